// File: rtl/uart_sprite_loader_pkg.sv
// Shared constants for the UART sprite loader: FSM state codes, CMD byte fields, sync marker.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_loader_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  // CMD byte layout: [7:5] target, [4:0] word count minus one
  localparam int CMD_TGT_LSB = 5;
  localparam int CMD_TGT_W   = 3;
  localparam int CMD_LEN_LSB = 0;
  localparam int CMD_LEN_W   = 5;

  // Default packet start marker
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_sprite_loader_if.sv
// Byte-in / write-out bundle between uart_rx, the loader and the sprite controller.
// Latency: n/a (wiring only).
// Backpressure: none; the byte strobe and write strobe are both fire-and-forget.
interface uart_sprite_loader_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              rcv_i;
  logic [7:0]        uart_data_i;
  logic              mw_o;
  logic [ADDR_W-1:0] address_o;
  logic [DATA_W-1:0] data_o;
  logic [7:0]        leds_o;
  logic              busy_o;
  logic              err_o;
  logic [7:0]        err_cnt_o;

  // Byte source / write sink side
  modport master (
    output rcv_i, uart_data_i,
    input  mw_o, address_o, data_o, leds_o, busy_o, err_o, err_cnt_o
  );

  // Loader side
  modport slave (
    input  rcv_i, uart_data_i,
    output mw_o, address_o, data_o, leds_o, busy_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/uart_sprite_loader_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, pulses expire_o at TIMEOUT_CYC-1.
// Latency: expire_o is combinational from the count register (same cycle).
// Backpressure: none; clear has priority over expiry so a byte in the expiry cycle wins.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and park at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_sprite_loader.sv
// Framed UART packet decoder -> burst sprite-memory writes (optional per-word XOR check: UART_LOADER_CSUM_EN).
// Latency: mw_o one cycle after the byte that completes a word (data byte, or CSUM byte when enabled).
// Backpressure: none; one byte per rcv_i is always accepted, errors abort the packet back to IDLE.
module uart_sprite_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_W      = 30,
  parameter int         DATA_W      = 32,
  parameter int         ADDR_BYTES  = 2,
  parameter int         TGT_LSB     = 27,
  parameter int         ADDR_STEP   = 4,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  uart_sprite_loader_if.slave bus
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam int LO_W       = 8 * ADDR_BYTES;
  localparam int IDX_W      = 8;

  logic [2:0]           state_q, state_d;
  logic [CMD_TGT_W-1:0] target_q, target_d;
  logic [CMD_LEN_W-1:0] words_left_q, words_left_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LO_W-1:0]      addr_lo_q, addr_lo_d;
  logic [DATA_W-1:0]    word_q, word_d;
  logic                 mw_q, mw_d;
  logic [ADDR_W-1:0]    address_q, address_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [7:0]           leds_q, leds_d;
  logic                 err_q, err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic              rcv;
  logic [7:0]        rx_byte;
  logic              expire;
  logic              commit;
  logic              raise_err;
  logic [DATA_W-1:0] commit_word;
  logic [DATA_W-1:0] word_next;
  logic [LO_W-1:0]   lo_next;

  assign rcv     = bus.rcv_i;
  assign rx_byte = bus.uart_data_i;

  // Bytes arrive LSB first, so each new byte enters at the top and the rest shift down
  assign word_next = (DATA_W'(rx_byte) << (DATA_W - 8)) | (word_q >> 8);
  assign lo_next   = (LO_W'(rx_byte) << (LO_W - 8)) | (addr_lo_q >> 8);

  // Full address: target in its fixed field, low address at the bottom, zeros between
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [CMD_TGT_W-1:0] tgt,
                                                input logic [LO_W-1:0] lo);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[TGT_LSB +: CMD_TGT_W] = tgt;
    a[LO_W-1:0] = lo;
    return a;
  endfunction

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (rcv || (state_q == ST_IDLE)),
    .en_i     (state_q != ST_IDLE),
    .expire_o (expire)
  );

  // Packet FSM, byte assembly, write issue and error accounting
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    addr_lo_d    = addr_lo_q;
    word_d       = word_q;
    mw_d         = 1'b0;
    address_d    = address_q;
    data_d       = data_q;
    leds_d       = leds_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    commit       = 1'b0;
    commit_word  = word_next;
    raise_err    = 1'b0;

    if (rcv) leds_d = rx_byte;

    case (state_q)
      ST_IDLE: begin
        if (rcv && (rx_byte == SYNC_BYTE)) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (rcv) begin
          target_d     = rx_byte[CMD_TGT_LSB +: CMD_TGT_W];
          words_left_d = rx_byte[CMD_LEN_LSB +: CMD_LEN_W];
          idx_d        = '0;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rcv) begin
          addr_lo_d = lo_next;
          if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (rcv) begin
          word_d = word_next;
          if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
            idx_d = '0;
`ifdef UART_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            commit = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_LOADER_CSUM_EN
      ST_CSUM: begin
        if (rcv) begin
          if (rx_byte == csum_q) begin
            commit      = 1'b1;
            commit_word = word_q;
          end else begin
            raise_err = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A finished word becomes one write; the low address wraps, target bits stay put
    if (commit) begin
      mw_d      = 1'b1;
      data_d    = commit_word;
      address_d = mk_addr(target_q, addr_lo_q);
      addr_lo_d = addr_lo_q + LO_W'(ADDR_STEP);
      if (words_left_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        words_left_d = words_left_q - CMD_LEN_W'(1);
        state_d      = ST_DATA;
      end
    end

    // Expiry never coincides with a byte, so it cannot collide with a commit
    if (expire) begin
      state_d   = ST_IDLE;
      raise_err = 1'b1;
    end

    if (raise_err) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

`ifdef UART_LOADER_CSUM_EN
  // Running XOR over CMD, address and data bytes of the current packet
  always_comb begin
    csum_d = csum_q;
    if (rcv) begin
      if (state_q == ST_CMD) csum_d = rx_byte;
      else if ((state_q == ST_ADDR) || (state_q == ST_DATA)) csum_d = csum_q ^ rx_byte;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (!rstn) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  // State and output registers, all cleared by reset (drops any partial word)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      addr_lo_q    <= '0;
      word_q       <= '0;
      mw_q         <= 1'b0;
      address_q    <= '0;
      data_q       <= '0;
      leds_q       <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      addr_lo_q    <= addr_lo_d;
      word_q       <= word_d;
      mw_q         <= mw_d;
      address_q    <= address_d;
      data_q       <= data_d;
      leds_q       <= leds_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.mw_o      = mw_q;
  assign bus.address_o = address_q;
  assign bus.data_o    = data_q;
  assign bus.leds_o    = leds_q;
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = err_cnt_q;

endmodule
